// File: rtl/sequencer_pkg.sv
// Shared encodings and helpers for the A/B/C stimulus sequencer.
package sequencer_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned STEP_W  = 3;

  localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] S_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] S_DONE = 2'd2;

  localparam logic [STEP_W-1:0] LAST_STEP = 3'd7;

  // Reflected binary Gray code of a 3-bit step number.
  function automatic logic [STEP_W-1:0] bin2gray3(input logic [STEP_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Counts cycles within one pattern; tick marks the last cycle of the dwell.
module dwell_timer #(
  parameter int unsigned DWELL   = 8,
  parameter int unsigned DWELL_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [DWELL_W-1:0] count_q;
  logic               at_last;

  assign at_last = (count_q == DWELL_W'(DWELL - 1));
  assign tick    = en && at_last;

  // Dwell counter: clear wins, otherwise wrap at DWELL-1 while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      if (at_last) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + DWELL_W'(1);
      end
    end
  end

endmodule

// File: rtl/abc_stimulus_sequencer.sv
// Sweeps {A,B,C} through all eight 3-bit codes in binary or Gray order,
// holding each for DWELL cycles, with a start/busy/done/abort handshake.
module abc_stimulus_sequencer
  import sequencer_pkg::*;
#(
  parameter int unsigned DWELL   = 8,
  parameter int unsigned DWELL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic              repeat_en,
  input  logic              abort,
  output logic              A,
  output logic              B,
  output logic              C,
  output logic              valid,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] step_idx
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [STEP_W-1:0]  step_d;
  logic [STEP_W-1:0]  abc_d;
  logic               mode_q;
  logic               mode_d;
  logic               valid_d;
  logic               busy_d;
  logic               done_d;
  logic               tick;
  logic               timer_en;
  logic               timer_clr;

  // Timer runs only in RUN; leaving RUN or aborting returns it to zero.
  assign timer_en  = (state_q == S_RUN);
  assign timer_clr = (state_q != S_RUN) || abort;

  dwell_timer #(
    .DWELL   (DWELL),
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .en    (timer_en),
    .tick  (tick)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      step_idx <= '0;
      mode_q   <= 1'b0;
      {A, B, C} <= 3'b000;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_idx <= step_d;
      mode_q   <= mode_d;
      {A, B, C} <= abc_d;
      valid    <= valid_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Next state: abort outranks completion; DONE always falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (tick && (step_idx == LAST_STEP) && !repeat_en) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the upcoming state, registered above.
  always_comb begin
    step_d  = '0;
    mode_d  = mode_q;
    abc_d   = '0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      S_RUN: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        if (state_q == S_IDLE) begin
          step_d = '0;
          mode_d = mode;
        end else if (tick) begin
          step_d = step_idx + 3'd1;
        end else begin
          step_d = step_idx;
        end
        abc_d = mode_d ? bin2gray3(step_d) : step_d;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
